// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline stall/flush sequencer.
package pipe_ctrl_pkg;

    typedef enum logic {CTRL_RUN, CTRL_PEND} ctrl_state_e;

    typedef struct packed {
        logic stall;
        logic flush;
    } stage_ctrl_t;

    localparam int unsigned REG_ZERO = 0;

    // A flushed register takes a bubble, so its stall is irrelevant.
    function automatic logic eff_stall(stage_ctrl_t s);
        return s.stall & ~s.flush;
    endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Hazard inputs from the pipeline and the per-stage control outputs back to it.
interface pipe_hazard_ctrl_if #(
    parameter int unsigned REG_AW = 5,
    parameter int unsigned PC_W   = 32
);
    logic [REG_AW-1:0] id_rs;
    logic [REG_AW-1:0] id_rt;
    logic              id_use_rs;
    logic              id_use_rt;
    logic [REG_AW-1:0] ex_rd;
    logic              ex_mem_read;
    logic              ex_redirect;
    logic [PC_W-1:0]   ex_target;
    logic              if_busy;
    logic              mem_busy;
    logic              md_busy;

    logic              pc_stall;
    logic              pc_load;
    logic [PC_W-1:0]   pc_target;
    logic              ifid_stall;
    logic              ifid_flush;
    logic              idex_stall;
    logic              idex_flush;
    logic              exmem_stall;
    logic              exmem_flush;
    logic              memwb_flush;

    modport master (
        output id_rs, id_rt, id_use_rs, id_use_rt, ex_rd, ex_mem_read,
               ex_redirect, ex_target, if_busy, mem_busy, md_busy,
        input  pc_stall, pc_load, pc_target, ifid_stall, ifid_flush,
               idex_stall, idex_flush, exmem_stall, exmem_flush, memwb_flush
    );

    modport slave (
        input  id_rs, id_rt, id_use_rs, id_use_rt, ex_rd, ex_mem_read,
               ex_redirect, ex_target, if_busy, mem_busy, md_busy,
        output pc_stall, pc_load, pc_target, ifid_stall, ifid_flush,
               idex_stall, idex_flush, exmem_stall, exmem_flush, memwb_flush
    );

endinterface

// File: rtl/pipe_hazard_ctrl_stall_watchdog.sv
// Counts consecutive stall cycles (saturating) and raises a sticky error at the limit.
module stall_watchdog #(
    parameter int unsigned WDOG_W = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic stall,
    output logic err
);
    localparam logic [WDOG_W-1:0] CNT_MAX = '1;

    logic [WDOG_W-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
            err <= 1'b0;
        end else if (stall) begin
            if (cnt != CNT_MAX) cnt <= cnt + 1'b1;
            // Error lands on the same edge the count reaches the limit.
            if (cnt >= CNT_MAX - WDOG_W'(1)) err <= 1'b1;
        end else begin
            cnt <= '0;
        end
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Central stall/flush sequencer: merges load-use, redirect and busy hazards into stage controls.
module pipe_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned REG_AW  = 5,
    parameter int unsigned PC_W    = 32,
    parameter int unsigned WDOG_W  = 16,
    parameter int unsigned STCNT_W = 32
) (
    input  logic               clk,
    input  logic               rst,
    pipe_hazard_ctrl_if.slave  bus,
    output logic [STCNT_W-1:0] stall_cycles,
    output logic               wdog_err
);
    ctrl_state_e     state_q, state_d;
    logic [PC_W-1:0] pend_q;
    logic            latch_en;
    logic            load_use;
    logic            pc_stall, pc_load;
    logic [PC_W-1:0] pc_target;
    stage_ctrl_t     ifid, idex, exmem, memwb;

    assign load_use = bus.ex_mem_read && (bus.ex_rd != REG_AW'(REG_ZERO)) &&
                      ((bus.id_use_rs && bus.id_rs == bus.ex_rd) ||
                       (bus.id_use_rt && bus.id_rt == bus.ex_rd));

    always_comb begin
        state_d   = state_q;
        latch_en  = 1'b0;
        pc_stall  = 1'b0;
        pc_load   = 1'b0;
        pc_target = '0;
        ifid      = '0;
        idex      = '0;
        exmem     = '0;
        memwb     = '0;
        if (state_q == CTRL_PEND) begin
            pc_stall   = 1'b1;
            ifid.flush = 1'b1;
            if (bus.mem_busy) begin
                idex.stall  = 1'b1;
                exmem.stall = 1'b1;
                memwb.flush = 1'b1;
            end else if (bus.md_busy) begin
                idex.stall  = 1'b1;
                exmem.flush = 1'b1;
            end else if (bus.ex_redirect) begin
                idex.flush = 1'b1;
                latch_en   = 1'b1;
            end
            // A redirect resolving in the exit cycle is the newest target.
            if (!bus.if_busy && !bus.mem_busy) begin
                pc_stall  = 1'b0;
                pc_load   = 1'b1;
                pc_target = latch_en ? bus.ex_target : pend_q;
                state_d   = CTRL_RUN;
            end
        end else if (bus.mem_busy) begin
            pc_stall    = 1'b1;
            ifid.stall  = 1'b1;
            idex.stall  = 1'b1;
            exmem.stall = 1'b1;
            memwb.flush = 1'b1;
        end else if (bus.md_busy) begin
            pc_stall    = 1'b1;
            ifid.stall  = 1'b1;
            idex.stall  = 1'b1;
            exmem.flush = 1'b1;
        end else if (bus.ex_redirect) begin
            ifid.flush = 1'b1;
            idex.flush = 1'b1;
            if (bus.if_busy) begin
                pc_stall = 1'b1;
                latch_en = 1'b1;
                state_d  = CTRL_PEND;
            end else begin
                pc_load   = 1'b1;
                pc_target = bus.ex_target;
            end
        end else if (load_use) begin
            pc_stall   = 1'b1;
            ifid.stall = 1'b1;
            idex.flush = 1'b1;
        end else if (bus.if_busy) begin
            pc_stall   = 1'b1;
            ifid.flush = 1'b1;
        end
        if (rst) begin
            pc_stall  = 1'b0;
            pc_load   = 1'b0;
            pc_target = '0;
            ifid      = '0;
            idex      = '0;
            exmem     = '0;
            memwb     = '0;
        end
    end

    assign bus.pc_stall    = pc_stall;
    assign bus.pc_load     = pc_load;
    assign bus.pc_target   = pc_target;
    assign bus.ifid_stall  = eff_stall(ifid);
    assign bus.ifid_flush  = ifid.flush;
    assign bus.idex_stall  = eff_stall(idex);
    assign bus.idex_flush  = idex.flush;
    assign bus.exmem_stall = eff_stall(exmem);
    assign bus.exmem_flush = exmem.flush;
    assign bus.memwb_flush = memwb.flush;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= CTRL_RUN;
            pend_q       <= '0;
            stall_cycles <= '0;
        end else begin
            state_q <= state_d;
            if (latch_en) pend_q <= bus.ex_target;
            if (pc_stall) stall_cycles <= stall_cycles + 1'b1;
        end
    end

    stall_watchdog #(.WDOG_W(WDOG_W)) u_wdog (
        .clk   (clk),
        .rst   (rst),
        .stall (pc_stall),
        .err   (wdog_err)
    );

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed-vector bench for pipe_hazard_ctrl with hand-computed expected controls.
module tb_pipe_hazard_ctrl;

    logic        clk;
    logic        rst;
    logic [31:0] stall_cycles;
    logic        wdog_err;
    logic [8:0]  ctl;
    int unsigned n_cmp = 0;
    int unsigned n_err = 0;
    int unsigned exp_stalls = 0;

    pipe_hazard_ctrl_if #(.REG_AW(5), .PC_W(32)) bus ();

    pipe_hazard_ctrl #(.REG_AW(5), .PC_W(32), .WDOG_W(4), .STCNT_W(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .bus          (bus),
        .stall_cycles (stall_cycles),
        .wdog_err     (wdog_err)
    );

    // {pc_stall, pc_load, ifid_stall, ifid_flush, idex_stall, idex_flush, exmem_stall, exmem_flush, memwb_flush}
    assign ctl = {bus.pc_stall, bus.pc_load, bus.ifid_stall, bus.ifid_flush,
                  bus.idex_stall, bus.idex_flush, bus.exmem_stall, bus.exmem_flush,
                  bus.memwb_flush};

    localparam logic [8:0] C_IDLE   = 9'h000;
    localparam logic [8:0] C_LDUSE  = 9'h148;
    localparam logic [8:0] C_REDIR  = 9'h0A8;
    localparam logic [8:0] C_REDIRB = 9'h128;
    localparam logic [8:0] C_PEND   = 9'h120;
    localparam logic [8:0] C_PEXIT  = 9'h0A0;
    localparam logic [8:0] C_MEM    = 9'h155;
    localparam logic [8:0] C_MD     = 9'h152;
    localparam logic [8:0] C_IFB    = 9'h120;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic clr_in();
        bus.id_rs       = '0;
        bus.id_rt       = '0;
        bus.id_use_rs   = 1'b0;
        bus.id_use_rt   = 1'b0;
        bus.ex_rd       = '0;
        bus.ex_mem_read = 1'b0;
        bus.ex_redirect = 1'b0;
        bus.ex_target   = '0;
        bus.if_busy     = 1'b0;
        bus.mem_busy    = 1'b0;
        bus.md_busy     = 1'b0;
    endtask

    task automatic set_ld(input logic [4:0] rd, input logic [4:0] rs, input logic urs,
                          input logic [4:0] rt, input logic urt);
        bus.ex_mem_read = 1'b1;
        bus.ex_rd       = rd;
        bus.id_rs       = rs;
        bus.id_use_rs   = urs;
        bus.id_rt       = rt;
        bus.id_use_rt   = urt;
    endtask

    initial begin
        rst = 1'b1;
        clr_in();
        #12;
        check("rst_ctl", 64'(ctl), 64'(C_IDLE));
        check("rst_tgt", 64'(bus.pc_target), 64'h0);
        check("rst_cnt", 64'(stall_cycles), 64'h0);
        check("rst_wdog", 64'(wdog_err), 64'h0);
        rst = 1'b0;
        cyc();

        // Load-use on rs, then rd==0, rs unused, and rt match
        set_ld(5'd3, 5'd3, 1'b1, 5'd0, 1'b0); #1;
        check("lu_rs", 64'(ctl), 64'(C_LDUSE));
        cyc(); exp_stalls += 1;
        set_ld(5'd0, 5'd0, 1'b1, 5'd0, 1'b0); #1;
        check("lu_rd0", 64'(ctl), 64'(C_IDLE));
        set_ld(5'd3, 5'd3, 1'b0, 5'd7, 1'b1); #1;
        check("lu_nouse", 64'(ctl), 64'(C_IDLE));
        set_ld(5'd7, 5'd3, 1'b0, 5'd7, 1'b1); #1;
        check("lu_rt", 64'(ctl), 64'(C_LDUSE));
        cyc(); exp_stalls += 1;
        clr_in(); #1;
        check("lu_done", 64'(ctl), 64'(C_IDLE));

        // Redirect with fetch idle
        bus.ex_redirect = 1'b1; bus.ex_target = 32'h100; #1;
        check("rd_ctl", 64'(ctl), 64'(C_REDIR));
        check("rd_tgt", 64'(bus.pc_target), 64'h100);
        cyc();
        clr_in(); #1;
        check("rd_after", 64'(ctl), 64'(C_IDLE));
        cyc();

        // Redirect under if_busy: pending, applied once
        bus.ex_redirect = 1'b1; bus.ex_target = 32'h200; bus.if_busy = 1'b1; #1;
        check("pb_enter", 64'(ctl), 64'(C_REDIRB));
        cyc(); exp_stalls += 1;
        bus.ex_redirect = 1'b0; bus.ex_target = 32'hDEAD;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("pb_pend", 64'(ctl), 64'(C_PEND));
            cyc(); exp_stalls += 1;
        end
        bus.if_busy = 1'b0; #1;
        check("pb_exit", 64'(ctl), 64'(C_PEXIT));
        check("pb_tgt", 64'(bus.pc_target), 64'h200);
        cyc();
        clr_in(); #1;
        check("pb_once", 64'(ctl), 64'(C_IDLE));
        check("pb_cnt", 64'(stall_cycles), 64'(exp_stalls));

        // mem_busy freezes EX, redirect waits
        bus.mem_busy = 1'b1; bus.ex_redirect = 1'b1; bus.ex_target = 32'h300;
        for (int i = 0; i < 4; i++) begin
            #1;
            check("mb_frz", 64'(ctl), 64'(C_MEM));
            cyc(); exp_stalls += 1;
        end
        bus.mem_busy = 1'b0; #1;
        check("mb_rel", 64'(ctl), 64'(C_REDIR));
        check("mb_tgt", 64'(bus.pc_target), 64'h300);
        check("mb_cnt", 64'(stall_cycles), 64'(exp_stalls));
        cyc();
        clr_in();

        // Load-use and redirect together: redirect wins
        set_ld(5'd4, 5'd4, 1'b1, 5'd0, 1'b0);
        bus.ex_redirect = 1'b1; bus.ex_target = 32'h400; #1;
        check("lr_ctl", 64'(ctl), 64'(C_REDIR));
        check("lr_tgt", 64'(bus.pc_target), 64'h400);
        cyc();
        clr_in();

        // md_busy and plain if_busy
        bus.md_busy = 1'b1; #1;
        check("md_ctl", 64'(ctl), 64'(C_MD));
        cyc(); exp_stalls += 1;
        clr_in(); bus.if_busy = 1'b1; #1;
        check("ifb_ctl", 64'(ctl), 64'(C_IFB));
        cyc(); exp_stalls += 1;
        clr_in(); #1;
        check("cnt_mid", 64'(stall_cycles), 64'(exp_stalls));
        cyc();

        // Watchdog: 15 consecutive stalls at WDOG_W=4
        check("wd_pre", 64'(wdog_err), 64'h0);
        bus.mem_busy = 1'b1;
        for (int i = 0; i < 14; i++) begin
            cyc(); exp_stalls += 1;
        end
        check("wd_14", 64'(wdog_err), 64'h0);
        cyc(); exp_stalls += 1;
        check("wd_15", 64'(wdog_err), 64'h1);
        bus.mem_busy = 1'b0;
        cyc(); cyc();
        check("wd_sticky", 64'(wdog_err), 64'h1);
        check("wd_cnt", 64'(stall_cycles), 64'(exp_stalls));

        // Reset while a redirect is pending
        bus.ex_redirect = 1'b1; bus.ex_target = 32'h500; bus.if_busy = 1'b1;
        cyc();
        bus.ex_redirect = 1'b0;
        rst = 1'b1; #1;
        check("rp_ctl", 64'(ctl), 64'(C_IDLE));
        check("rp_tgt", 64'(bus.pc_target), 64'h0);
        check("rp_cnt", 64'(stall_cycles), 64'h0);
        check("rp_wdog", 64'(wdog_err), 64'h0);
        cyc(); #2;
        rst = 1'b0; bus.if_busy = 1'b0; #1;
        check("rp_run", 64'(ctl), 64'(C_IDLE));
        check("rp_tgt2", 64'(bus.pc_target), 64'h0);
        cyc();
        check("rp_cnt2", 64'(stall_cycles), 64'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
